// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller.
//   - Parameter defaults for the number of lines and the ID width.
//   - FSM state encoding (IDLE=0, REQ=1, SERVICE=2).
//   - lowest_set(): fixed-priority pick of the lowest set bit of an
//     enabled-pending vector, sized for the largest legal line count.
package int_controller_pkg;

  localparam int N_IRQ_DEF = 4;
  localparam int ID_W_DEF  = 2;
  localparam int N_IRQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Returns the index of the lowest set bit; 0 when the vector is empty
  // (callers only use the result when at least one bit is set).
  function automatic logic [2:0] lowest_set(input logic [N_IRQ_MAX-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_IRQ_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-line interrupt input conditioner.
//   clk   : system clock
//   reset : asynchronous, active-low
//   din   : raw asynchronous interrupt line
//   evt   : one-cycle pulse on a synchronized rising edge of din
// Two flops synchronize din; a third holds the previous synchronized value
// so a rising edge is sync & ~prev. All flops clear on reset, so a line
// held high through reset release still yields one event.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic evt
);

  logic sync1;
  logic sync2;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchronizer chain into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign evt = sync2 & ~prev;

endmodule

// File: rtl/int_controller.sv
// Fixed-priority interrupt controller with a request/ack/done handshake.
//   clk       : system clock, all state on the rising edge
//   reset     : asynchronous, active-low
//   int_in    : raw interrupt lines, a rising edge is an event
//   en_we     : enable-register write strobe
//   en_wdata  : enable value written when en_we=1
//   en_q      : current enable register
//   pending_q : current pending register (set regardless of enable)
//   intr_req  : registered request to the CPU
//   intr_id   : registered ID of the requested / in-service line
//   intr_ack  : CPU accepts the request (honoured only in REQ)
//   intr_done : CPU end of service (honoured only in SERVICE)
// After every return to IDLE the arbiter waits one cycle before it may
// issue a new request, giving a two-cycle gap between back-to-back
// services. ID_W must equal clog2(N_IRQ); N_IRQ is legal from 2 to 8.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] int_in,
  input  logic             en_we,
  input  logic [N_IRQ-1:0] en_wdata,
  output logic [N_IRQ-1:0] en_q,
  output logic [N_IRQ-1:0] pending_q,
  output logic             intr_req,
  output logic [ID_W-1:0]  intr_id,
  input  logic             intr_ack,
  input  logic             intr_done
);

  logic [N_IRQ-1:0]     evt;
  logic [N_IRQ-1:0]     ep;
  logic [N_IRQ-1:0]     clr;
  logic [N_IRQ-1:0]     pending_d;
  logic [N_IRQ-1:0]     en_d;
  logic [N_IRQ_MAX-1:0] ep_ext;
  logic [2:0]           winner;
  logic [ID_W-1:0]      id_d;
  logic                 hold_q;
  logic                 hold_d;
  state_t               state_q;
  state_t               state_d;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (int_in[i]),
      .evt   (evt[i])
    );
  end

  assign ep = pending_q & en_q;

  always_comb begin
    ep_ext           = '0;
    ep_ext[N_IRQ-1:0] = ep;
  end

  assign winner = lowest_set(ep_ext);

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    id_d    = intr_id;
    hold_d  = 1'b0;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        // hold_q blocks arbitration for the first cycle back in IDLE.
        if (!hold_q && (ep != '0)) begin
          state_d = REQ;
          id_d    = winner[ID_W-1:0];
        end
      end
      REQ: begin
        // The ack takes precedence over a simultaneous disable of the
        // requested line; the enable write itself still lands via en_d.
        if (intr_ack) begin
          state_d      = SERVICE;
          clr[intr_id] = 1'b1;
        end else if (en_we && !en_wdata[intr_id]) begin
          state_d = IDLE;
          hold_d  = 1'b1;
        end
      end
      SERVICE: begin
        if (intr_done) begin
          state_d = IDLE;
          hold_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new event outranks the clear of the same bit.
  assign pending_d = (pending_q & ~clr) | evt;
  assign en_d      = en_we ? en_wdata : en_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hold_q    <= 1'b0;
      intr_req  <= 1'b0;
      intr_id   <= '0;
      pending_q <= '0;
      en_q      <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      intr_req  <= (state_d == REQ);
      intr_id   <= id_d;
      pending_q <= pending_d;
      en_q      <= en_d;
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios plus a
// randomized run compared against a behavioural model of the controller.
module tb_int_controller;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] int_in;
  logic         en_we;
  logic [N-1:0] en_wdata;
  logic [N-1:0] en_q;
  logic [N-1:0] pending_q;
  logic         intr_req;
  logic [W-1:0] intr_id;
  logic         intr_ack;
  logic         intr_done;

  int checks = 0;
  int errors = 0;

  int_controller #(.N_IRQ(N), .ID_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .int_in    (int_in),
    .en_we     (en_we),
    .en_wdata  (en_wdata),
    .en_q      (en_q),
    .pending_q (pending_q),
    .intr_req  (intr_req),
    .intr_id   (intr_id),
    .intr_ack  (intr_ack),
    .intr_done (intr_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // s1/s2/s3: int_in as sampled at the last three rising edges. A line
  // whose sample two edges ago is 1 and three edges ago is 0 becomes
  // pending at this edge.
  logic [N-1:0] m_s1, m_s2, m_s3, m_pend, m_en;
  bit           m_req, m_serv, m_wait;
  int           m_id;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_s3 = '0;
    m_pend = '0; m_en = '0;
    m_req = 0; m_serv = 0; m_wait = 0; m_id = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] events;
    logic [N-1:0] cleared;
    bit n_req, n_serv, n_wait;
    int n_id;
    events  = m_s2 & ~m_s3;
    cleared = '0;
    n_req = m_req; n_serv = m_serv; n_wait = 0; n_id = m_id;
    if (m_req) begin
      if (intr_ack) begin
        cleared[m_id] = 1'b1; n_req = 0; n_serv = 1;
      end else if (en_we && !en_wdata[m_id]) begin
        n_req = 0; n_wait = 1;
      end
    end else if (m_serv) begin
      if (intr_done) begin n_serv = 0; n_wait = 1; end
    end else if (!m_wait) begin
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i] && m_en[i]) begin n_req = 1; n_id = i; end
    end
    m_pend = (m_pend & ~cleared) | events;
    if (en_we) m_en = en_wdata;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = int_in;
    m_req = n_req; m_serv = n_serv; m_wait = n_wait; m_id = n_id;
  endtask

  // One clock: advance the model at the edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic do_reset();
    intr_ack = 0; intr_done = 0; en_we = 0; en_wdata = '0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic write_en(input logic [N-1:0] v);
    en_we = 1; en_wdata = v;
    step();
    en_we = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++; if (pending_q !== '0) begin errors++; $display("FAIL reset_pending: got %b exp 0000", pending_q); end
    checks++; if (en_q !== '0) begin errors++; $display("FAIL reset_en: got %b exp 0000", en_q); end
    checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", intr_req); end
    checks++; if (intr_id !== '0) begin errors++; $display("FAIL reset_id: got %0d exp 0", intr_id); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_event();
    do_reset();
    write_en(4'b1111);
    int_in = 4'b0100;
    step(); step();
    checks++; if (pending_q !== 4'b0000) begin errors++; $display("FAIL single_early_pend: got %b exp 0000", pending_q); end
    step();
    checks++; if (pending_q !== 4'b0100) begin errors++; $display("FAIL single_pend: got %b exp 0100", pending_q); end
    checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b exp 0", intr_req); end
    step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd2) begin errors++; $display("FAIL single_req: got req=%b id=%0d exp req=1 id=2", intr_req, intr_id); end
    step(); step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd2) begin errors++; $display("FAIL single_hold: got req=%b id=%0d exp req=1 id=2", intr_req, intr_id); end
    intr_ack = 1; step(); intr_ack = 0;
    checks++; if (intr_req !== 1'b0 || pending_q !== 4'b0000 || intr_id !== 2'd2) begin errors++; $display("FAIL single_ack: got req=%b pend=%b id=%0d exp req=0 pend=0000 id=2", intr_req, pending_q, intr_id); end
    intr_done = 1; step(); intr_done = 0;
    step(); step();
    checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL single_after_done: got %b exp 0", intr_req); end
    int_in = '0;
  endtask

  task automatic test_priority();
    do_reset();
    write_en(4'b1111);
    int_in = 4'b1010;
    step(); step(); step();
    checks++; if (pending_q !== 4'b1010) begin errors++; $display("FAIL prio_pend: got %b exp 1010", pending_q); end
    step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd1) begin errors++; $display("FAIL prio_first: got req=%b id=%0d exp req=1 id=1", intr_req, intr_id); end
    intr_ack = 1; step(); intr_ack = 0;
    checks++; if (pending_q !== 4'b1000 || intr_req !== 1'b0) begin errors++; $display("FAIL prio_ack: got pend=%b req=%b exp pend=1000 req=0", pending_q, intr_req); end
    // An ack outside REQ is ignored.
    intr_ack = 1; step(); intr_ack = 0;
    checks++; if (pending_q !== 4'b1000 || intr_req !== 1'b0) begin errors++; $display("FAIL prio_stray_ack: got pend=%b req=%b exp pend=1000 req=0", pending_q, intr_req); end
    intr_done = 1; step(); intr_done = 0;
    step();
    checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL prio_gap: got %b exp 0", intr_req); end
    step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd3) begin errors++; $display("FAIL prio_second: got req=%b id=%0d exp req=1 id=3", intr_req, intr_id); end
    // A done outside SERVICE is ignored.
    intr_done = 1; step(); intr_done = 0;
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd3) begin errors++; $display("FAIL prio_stray_done: got req=%b id=%0d exp req=1 id=3", intr_req, intr_id); end
    int_in = '0;
  endtask

  task automatic test_masked();
    do_reset();
    int_in = 4'b0001;
    step(); step(); step(); step(); step();
    checks++; if (pending_q !== 4'b0001 || intr_req !== 1'b0) begin errors++; $display("FAIL mask_pend: got pend=%b req=%b exp pend=0001 req=0", pending_q, intr_req); end
    write_en(4'b0001);
    checks++; if (en_q !== 4'b0001 || intr_req !== 1'b0) begin errors++; $display("FAIL mask_en: got en=%b req=%b exp en=0001 req=0", en_q, intr_req); end
    step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd0) begin errors++; $display("FAIL mask_req: got req=%b id=%0d exp req=1 id=0", intr_req, intr_id); end
    int_in = '0;
  endtask

  task automatic test_set_wins();
    do_reset();
    write_en(4'b1111);
    int_in = 4'b0010;
    step(); step(); step(); step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd1) begin errors++; $display("FAIL setwin_req: got req=%b id=%0d exp req=1 id=1", intr_req, intr_id); end
    int_in = 4'b0000; step();
    int_in = 4'b0010; step();
    step();
    intr_ack = 1; step(); intr_ack = 0;
    checks++; if (pending_q[1] !== 1'b1 || intr_req !== 1'b0) begin errors++; $display("FAIL setwin_pend: got pend=%b req=%b exp pend[1]=1 req=0", pending_q, intr_req); end
    intr_done = 1; step(); intr_done = 0;
    step(); step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd1) begin errors++; $display("FAIL setwin_rereq: got req=%b id=%0d exp req=1 id=1", intr_req, intr_id); end
    int_in = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    write_en(4'b1111);
    int_in = 4'b0100;
    step(); step(); step(); step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd2) begin errors++; $display("FAIL wd_req: got req=%b id=%0d exp req=1 id=2", intr_req, intr_id); end
    write_en(4'b1011);
    checks++; if (intr_req !== 1'b0 || pending_q !== 4'b0100 || en_q !== 4'b1011) begin errors++; $display("FAIL wd_drop: got req=%b pend=%b en=%b exp req=0 pend=0100 en=1011", intr_req, pending_q, en_q); end
    step(); step(); step();
    checks++; if (intr_req !== 1'b0 || pending_q !== 4'b0100) begin errors++; $display("FAIL wd_stay: got req=%b pend=%b exp req=0 pend=0100", intr_req, pending_q); end
    // Ack together with the disable: the ack wins, the write still lands.
    write_en(4'b1111);
    step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd2) begin errors++; $display("FAIL wd_rereq: got req=%b id=%0d exp req=1 id=2", intr_req, intr_id); end
    intr_ack = 1; en_we = 1; en_wdata = 4'b1011; step(); intr_ack = 0; en_we = 0;
    checks++; if (intr_req !== 1'b0 || pending_q !== 4'b0000 || en_q !== 4'b1011) begin errors++; $display("FAIL wd_ackwins: got req=%b pend=%b en=%b exp req=0 pend=0000 en=1011", intr_req, pending_q, en_q); end
    intr_done = 1; step(); intr_done = 0;
    checks++; if (intr_req !== 1'b0 || intr_id !== 2'd2) begin errors++; $display("FAIL wd_done: got req=%b id=%0d exp req=0 id=2", intr_req, intr_id); end
    int_in = '0;
  endtask

  task automatic test_reset_in_service();
    do_reset();
    write_en(4'b1111);
    int_in = 4'b1011;
    step(); step(); step(); step();
    checks++; if (intr_req !== 1'b1 || intr_id !== 2'd0) begin errors++; $display("FAIL rsv_req: got req=%b id=%0d exp req=1 id=0", intr_req, intr_id); end
    intr_ack = 1; step(); intr_ack = 0;
    checks++; if (pending_q !== 4'b1010) begin errors++; $display("FAIL rsv_pend: got %b exp 1010", pending_q); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (pending_q !== '0 || en_q !== '0 || intr_req !== 1'b0 || intr_id !== '0) begin errors++; $display("FAIL rsv_async: got pend=%b en=%b req=%b id=%0d exp all 0", pending_q, en_q, intr_req, intr_id); end
    model_reset();
    int_in = '0;
    @(negedge clk);
    reset = 1'b1;
    intr_done = 1; step(); intr_done = 0;
    step(); step(); step();
    checks++; if (pending_q !== '0 || intr_req !== 1'b0) begin errors++; $display("FAIL rsv_after: got pend=%b req=%b exp pend=0000 req=0", pending_q, intr_req); end
  endtask

  task automatic test_high_through_reset();
    int_in = 4'b0010;
    do_reset();
    step(); step();
    checks++; if (pending_q !== 4'b0000) begin errors++; $display("FAIL hold_early: got %b exp 0000", pending_q); end
    step();
    checks++; if (pending_q !== 4'b0010) begin errors++; $display("FAIL hold_event: got %b exp 0010", pending_q); end
    int_in = '0;
  endtask

  task automatic test_random();
    logic [W-1:0] exp_id;
    do_reset();
    int_in = '0;
    write_en(logic'(1) ? 4'($urandom_range(1, 15)) : 4'b0);
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) int_in[b] = ~int_in[b];
      intr_ack  = ($urandom_range(0, 3) == 0);
      intr_done = ($urandom_range(0, 2) == 0);
      en_we     = ($urandom_range(0, 15) == 0);
      en_wdata  = 4'($urandom);
      step();
      exp_id = W'(m_id);
      checks++; if (pending_q !== m_pend) begin errors++; $display("FAIL rand_pend cyc %0d: got %b exp %b", c, pending_q, m_pend); end
      checks++; if (en_q !== m_en) begin errors++; $display("FAIL rand_en cyc %0d: got %b exp %b", c, en_q, m_en); end
      checks++; if (intr_req !== m_req) begin errors++; $display("FAIL rand_req cyc %0d: got %b exp %b", c, intr_req, m_req); end
      if (m_req || m_serv) begin
        checks++; if (intr_id !== exp_id) begin errors++; $display("FAIL rand_id cyc %0d: got %0d exp %0d", c, intr_id, exp_id); end
      end
    end
    intr_ack = 0; intr_done = 0; en_we = 0;
  endtask

  initial begin
    reset = 1'b0;
    int_in = '0; en_we = 0; en_wdata = '0; intr_ack = 0; intr_done = 0;
    model_reset();
    test_reset();
    test_single_event();
    test_priority();
    test_masked();
    test_set_wins();
    test_withdraw();
    test_reset_in_service();
    test_high_through_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
